uart_core: RTL
==============

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 3000000, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, character length; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, TX stop bits (1 or 2); RX always checks only the first stop bit.
REQ-006 Parameter OVERSAMPLE, default 8, ticks per bit; power of 2, at least 8.
REQ-007 clk  in  1  clock; the block uses one clock only.
REQ-008 rst_n  in  1  reset, synchronous and active-low.
REQ-009 tx_data  in  DATA_BITS  character to send, sampled on handshake.
REQ-010 tx_valid  in  1  tx_data valid.
REQ-011 tx_ready  out  1  transmitter idle, can accept a character.
REQ-012 txd  out  1  serial output; idle high.
REQ-013 rxd  in  1  asynchronous serial input.
REQ-014 rx_data  out  DATA_BITS  received character.
REQ-015 rx_valid  out  1  rx_data and its error flags are valid.
REQ-016 rx_ready  in  1  consumer accepts rx_data.
REQ-017 rx_parity_err  out  1  parity mismatch on the held character.
REQ-018 rx_frame_err  out  1  stop bit was 0 on the held character.
REQ-019 rx_overrun  out  1  one-cycle pulse: a completed character was dropped.

Function
REQ-020 Tick generator: 16-bit phase accumulator; INC = round(BAUD*OVERSAMPLE*2^16/CLK_FREQ); tick = carry out; free-running; elaboration error if INC is 0 or at least 2^16.
REQ-021 Bit period for TX and RX is exactly OVERSAMPLE ticks; data is sent and received LSB first.
REQ-022 TX handshake: transfer occurs when tx_valid and tx_ready are both high; tx_data is latched; tx_ready goes low the next cycle.
REQ-023 TX FSM: IDLE -> START(0) -> DATA[DATA_BITS] -> PARITY (if PARITY!=0) -> STOP[STOP_BITS](1) -> IDLE.
REQ-024 The start bit begins on the first tick after the handshake.
REQ-025 tx_ready rises the cycle after the last stop-bit tick.
REQ-026 Odd parity makes the count of ones in data plus parity odd; even parity makes it even.
REQ-027 RX input passes through a 2-FF synchroniser on clk, initialised to 1.
REQ-028 RX start detect: from IDLE, a low on the synchronised line starts a count of ticks; if the line is still low after OVERSAMPLE/2 ticks, the start is confirmed; if it goes high before that, the FSM returns to IDLE (glitch reject).
REQ-029 After start confirmation, each later bit is sampled every OVERSAMPLE ticks (mid-bit).
REQ-030 RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
REQ-031 On the stop-bit sample, rx_data and both error flags load the cycle after and rx_valid sets; the character is delivered even when an error flag is set.
REQ-032 rx_valid clears on rx_valid and rx_ready; data and flags are held until then.
REQ-033 If a character completes while rx_valid is high and rx_ready is low, the new character is discarded, the held character is unchanged, and rx_overrun pulses for 1 cycle.
REQ-034 If rx_valid, rx_ready and a completion occur in the same cycle, the new character loads, rx_valid stays 1, and there is no overrun.
REQ-035 After a frame error (break), RX stays out of IDLE until the synchronised line has been high for 1 tick, then re-arms.
REQ-036 TX and RX operate fully independently; simultaneous activity on both is legal.

Reset
REQ-037 On rst_n low at a clk edge, all FSMs go to IDLE and the accumulator to 0.
REQ-038 During reset, txd=1, tx_ready=0; rx_valid, rx_parity_err, rx_frame_err, rx_overrun and rx_data all read 0; synchroniser flops are set to 1.
REQ-039 tx_ready=1 the first cycle after rst_n goes high.
REQ-040 Reset mid-frame aborts the frame; txd reads 1 the cycle after the reset edge, and no partial character is delivered.

Structure
REQ-041 uart_pkg holds the parity mode constants, the TX/RX state enums and the INC computation function.
REQ-042 One sub-module, uart_tick_gen (accumulator, parameters CLK_FREQ, BAUD, OVERSAMPLE); a single instance is shared by TX and RX.

Verification (CLK_FREQ=16000000, BAUD=1000000, OVERSAMPLE=8 -> tick every 2 clocks, bit = 16 clocks)
REQ-043 8N1 TX: send 0xA5 -> txd shows 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; tx_ready returns high 160 clocks after the start bit.
REQ-044 8E2 loopback (txd tied to rxd): send 0x37 -> rx_data=0x37, parity bit 1, both error flags 0, rx_valid high for one handshake.
REQ-045 Errors: drive 0x55 with odd parity bit wrong and stop bit 0 -> rx_parity_err=1, rx_frame_err=1, data still 0x55; RX does not re-arm until rxd is high.
REQ-046 Glitch: rxd low for 6 clocks (fewer than 4 ticks) -> no start confirmed, rx_valid stays 0. Overrun: two back-to-back characters with rx_ready=0 -> rx_data holds the first and rx_overrun pulses exactly once.
REQ-047 Reset: assert rst_n=0 during bit 3 of a TX and an RX frame -> txd=1 next cycle, rx_valid=0, and a new frame after reset transfers correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX state encodings and the
// baud phase-accumulator increment.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // round(baud * os * 2^16 / clk_freq) in integer arithmetic
  function automatic longint unsigned calc_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input longint unsigned os);
    return (baud * os * 64'd131072 + clk_freq) / (2 * clk_freq);
  endfunction

endpackage

// File: rtl/uart_if.sv
// Character handshake and serial pins of the UART; slave is the core's view.
interface uart_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 txd;
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport slave (
    input  tx_data, tx_valid, rxd, rx_ready,
    output tx_ready, txd, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport master (
    output tx_data, tx_valid, rxd, rx_ready,
    input  tx_ready, txd, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_tick_gen.sv
// Free-running 16-bit phase accumulator; the carry out is the oversample tick.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 3000000,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);
  localparam longint unsigned INC_L = calc_inc(CLK_FREQ, BAUD, OVERSAMPLE);

  generate
    if (INC_L == 0 || INC_L >= 65536) begin : g_bad_inc
      $error("uart_tick_gen: increment out of range for CLK_FREQ/BAUD/OVERSAMPLE");
    end
  endgenerate

  localparam logic [16:0] INC = 17'(INC_L);

  logic [15:0] r_acc;
  logic [16:0] w_sum;

  assign w_sum  = {1'b0, r_acc} + INC;
  assign o_tick = w_sum[16];

  always_ff @(posedge clk) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= w_sum[15:0];
  end
endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX and RX FSMs driven by one shared oversample tick.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 3000000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 8
) (
  input logic   clk,
  input logic   rst_n,
  uart_if.slave bus
);
  localparam int unsigned    TCW    = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] T_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] T_HALF = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     S_LAST = 4'(STOP_BITS - 1);

  logic w_tick;

  uart_tick_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .rst_n(rst_n), .o_tick(w_tick)
  );

  tx_state_e            r_tx_st, w_tx_st;
  logic [TCW-1:0]       r_tx_tcnt, w_tx_tcnt;
  logic [3:0]           r_tx_bcnt, w_tx_bcnt;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh;
  logic                 r_tx_par, w_tx_par, r_tx_go, w_tx_go, r_txd, w_txd, r_tx_rdy, w_tx_end;

  // r_tx_go marks that the start bit has actually begun (first tick after handshake)
  always_comb begin
    w_tx_st   = r_tx_st;
    w_tx_tcnt = r_tx_tcnt;
    w_tx_bcnt = r_tx_bcnt;
    w_tx_sh   = r_tx_sh;
    w_tx_par  = r_tx_par;
    w_tx_go   = r_tx_go;
    w_txd     = r_txd;
    w_tx_end  = w_tick && r_tx_go && (r_tx_tcnt == T_LAST);
    if (w_tick && r_tx_go) w_tx_tcnt = r_tx_tcnt + 1'b1;
    case (r_tx_st)
      TX_IDLE: if (bus.tx_valid && r_tx_rdy) begin
        w_tx_st   = TX_START;
        w_tx_sh   = bus.tx_data;
        w_tx_par  = (PARITY == PAR_ODD) ? ~^bus.tx_data : ^bus.tx_data;
        w_tx_go   = 1'b0;
        w_tx_tcnt = '0;
      end
      TX_START: if (!r_tx_go) begin
        if (w_tick) begin
          w_tx_go = 1'b1;
          w_txd   = 1'b0;
        end
      end else if (w_tx_end) begin
        w_tx_st   = TX_DATA;
        w_tx_bcnt = '0;
        w_txd     = r_tx_sh[0];
      end
      TX_DATA: if (w_tx_end) begin
        if (r_tx_bcnt == D_LAST) begin
          w_tx_bcnt = '0;
          if (PARITY != PAR_NONE) begin
            w_tx_st = TX_PARITY;
            w_txd   = r_tx_par;
          end else begin
            w_tx_st = TX_STOP;
            w_txd   = 1'b1;
          end
        end else begin
          w_tx_bcnt = r_tx_bcnt + 1'b1;
          w_tx_sh   = r_tx_sh >> 1;
          w_txd     = r_tx_sh[1];
        end
      end
      TX_PARITY: if (w_tx_end) begin
        w_tx_st = TX_STOP;
        w_txd   = 1'b1;
      end
      TX_STOP: if (w_tx_end) begin
        if (r_tx_bcnt == S_LAST) begin
          w_tx_st = TX_IDLE;
          w_tx_go = 1'b0;
        end else begin
          w_tx_bcnt = r_tx_bcnt + 1'b1;
        end
      end
      default: w_tx_st = TX_IDLE;
    endcase
  end

  // tx_ready is registered so it reads 0 throughout reset and rises one cycle after it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_st   <= TX_IDLE;
      r_tx_tcnt <= '0;
      r_tx_bcnt <= '0;
      r_tx_sh   <= '0;
      r_tx_par  <= 1'b0;
      r_tx_go   <= 1'b0;
      r_txd     <= 1'b1;
      r_tx_rdy  <= 1'b0;
    end else begin
      r_tx_st   <= w_tx_st;
      r_tx_tcnt <= w_tx_tcnt;
      r_tx_bcnt <= w_tx_bcnt;
      r_tx_sh   <= w_tx_sh;
      r_tx_par  <= w_tx_par;
      r_tx_go   <= w_tx_go;
      r_txd     <= w_txd;
      r_tx_rdy  <= (w_tx_st == TX_IDLE);
    end
  end

  rx_state_e            r_rx_st, w_rx_st;
  logic [TCW-1:0]       r_rx_tcnt, w_rx_tcnt;
  logic [3:0]           r_rx_bcnt, w_rx_bcnt;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh, r_rx_data;
  logic                 r_s1, r_s2, r_rx_pbit, w_rx_pbit, w_rx_smp, w_rx_done, w_rx_perr;
  logic                 r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_ovr;

  always_comb begin
    w_rx_st   = r_rx_st;
    w_rx_tcnt = r_rx_tcnt;
    w_rx_bcnt = r_rx_bcnt;
    w_rx_sh   = r_rx_sh;
    w_rx_pbit = r_rx_pbit;
    w_rx_done = 1'b0;
    w_rx_smp  = w_tick && (r_rx_tcnt == T_LAST);
    w_rx_perr = (PARITY != PAR_NONE) && ((^r_rx_sh ^ r_rx_pbit) != (PARITY == PAR_ODD));
    if (w_tick) w_rx_tcnt = r_rx_tcnt + 1'b1;
    case (r_rx_st)
      RX_IDLE: begin
        w_rx_tcnt = '0;
        if (!r_s2) w_rx_st = RX_START;
      end
      RX_START: if (r_s2) begin
        w_rx_st = RX_IDLE;
      end else if (w_tick && r_rx_tcnt == T_HALF) begin
        w_rx_st   = RX_DATA;
        w_rx_tcnt = '0;
        w_rx_bcnt = '0;
      end
      RX_DATA: if (w_rx_smp) begin
        w_rx_sh = {r_s2, r_rx_sh[DATA_BITS-1:1]};
        if (r_rx_bcnt == D_LAST) w_rx_st = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        else                     w_rx_bcnt = r_rx_bcnt + 1'b1;
      end
      RX_PARITY: if (w_rx_smp) begin
        w_rx_pbit = r_s2;
        w_rx_st   = RX_STOP;
      end
      RX_STOP: if (w_rx_smp) begin
        w_rx_done = 1'b1;
        w_rx_st   = r_s2 ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: if (w_tick && r_s2) w_rx_st = RX_IDLE;
      default: w_rx_st = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1       <= 1'b1;
      r_s2       <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_sh    <= '0;
      r_rx_pbit  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_s1      <= bus.rxd;
      r_s2      <= r_s1;
      r_rx_st   <= w_rx_st;
      r_rx_tcnt <= w_rx_tcnt;
      r_rx_bcnt <= w_rx_bcnt;
      r_rx_sh   <= w_rx_sh;
      r_rx_pbit <= w_rx_pbit;
      r_rx_ovr  <= 1'b0;
      // a completion coinciding with the consumer's accept replaces the held character
      if (w_rx_done && (!r_rx_valid || bus.rx_ready)) begin
        r_rx_data  <= r_rx_sh;
        r_rx_perr  <= w_rx_perr;
        r_rx_ferr  <= !r_s2;
        r_rx_valid <= 1'b1;
      end else begin
        if (w_rx_done) r_rx_ovr <= 1'b1;
        if (r_rx_valid && bus.rx_ready) r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.tx_ready      = r_tx_rdy;
  assign bus.txd           = r_txd;
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_parity_err = r_rx_perr;
  assign bus.rx_frame_err  = r_rx_ferr;
  assign bus.rx_overrun    = r_rx_ovr;
endmodule
